// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver front-end.
// - Synchronises the serial line and decodes 8N1 frames using mid-bit sampling.
// - Buffers received bytes in a first-word-fall-through FIFO.
// - Presents the FIFO head on a valid/ready byte stream.
// - Reports framing and overrun errors as sticky flags.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, frames are 8E1
// and the sticky flag parity_err_o is added.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          uart_rx_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          frame_err_o,
    output logic                          overrun_err_o,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err_o,
`endif
    input  logic                          err_clr_i
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            brk_q, brk_d;
    logic            push_q, push_d;
    logic            frame_evt;
    logic            rx_s;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_err_q, overrun_err_d;
    logic            pop, full, wr_en, overrun_evt;

`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_evt;
    logic            parity_err_q, parity_err_d;
`endif

    // Two-flop synchroniser. The line idles high, so both stages reset to 1.
    always_comb begin
        sync_d = {sync_q[0], uart_rx_i};
    end
    assign rx_s = sync_q[1];

    // Frame decoder next-state logic.
    // The baud counter counts down to zero; each zero marks a sample point.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        brk_d     = brk_q;
        push_d    = 1'b0;
        frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_evt = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                brk_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s) begin
                    cnt_d   = CNT_W'(HALF_BIT - 1);
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        cnt_d     = CNT_W'(CLKS_PER_BIT - 1);
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    par_bad_d  = (^shift_q) ^ rx_s;
                    parity_evt = (^shift_q) ^ rx_s;
                    cnt_d      = CNT_W'(CLKS_PER_BIT - 1);
                    state_d    = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (brk_q) begin
                    if (rx_s) begin
                        brk_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (cnt_q == '0) begin
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push_d = !par_bad_q;
`else
                        push_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_evt = 1'b1;
                        brk_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO next-state logic.
    // The shift register still holds the byte on the cycle after the stop
    // sample, because nothing shifts until the next frame reaches DATA.
    // A pop in the same cycle as a push into a full FIFO frees the slot.
    always_comb begin
        pop         = rx_valid_o && rx_ready_i;
        full        = (count_q == CW'(FIFO_DEPTH));
        wr_en       = push_q && (!full || pop);
        overrun_evt = push_q && full && !pop;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // Sticky error flags. A new error event takes priority over a clear.
    always_comb begin
        frame_err_d   = frame_evt   | (frame_err_q   & ~err_clr_i);
        overrun_err_d = overrun_evt | (overrun_err_q & ~err_clr_i);
`ifdef UART_RX_PARITY_EN
        parity_err_d  = parity_evt  | (parity_err_q  & ~err_clr_i);
`endif
    end

    // State register for the synchroniser, decoder, FIFO and flags.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q        <= 2'b11;
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            brk_q         <= 1'b0;
            push_q        <= 1'b0;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            brk_q         <= brk_d;
            push_q        <= push_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_valid_o    = (count_q != '0);
    assign rx_data_o     = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count_o  = count_q;
    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo.
// - Runs with a short bit period of 16 clocks per bit.
// - Bytes that are expected to be received are queued as each frame is sent.
// - A monitor compares every byte the consumer accepts against that queue.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ   = 1600;
    localparam int BAUD       = 100;
    localparam int CPB        = CLK_FREQ / BAUD;
    localparam int FIFO_DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       uartRx;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic [3:0] fifoCount;
    logic       frameErr;
    logic       overrunErr;
    logic       errClr;
`ifdef UART_RX_PARITY_EN
    logic       parityErr;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];
    bit         trackMax = 0;
    int         maxCount = 0;

    uart_rx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_in       (clk),
        .rst          (rst),
        .uart_rx_i    (uartRx),
        .rx_data_o    (rxData),
        .rx_valid_o   (rxValid),
        .rx_ready_i   (rxReady),
        .fifo_count_o (fifoCount),
        .frame_err_o  (frameErr),
        .overrun_err_o(overrunErr),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parityErr),
`endif
        .err_clr_i    (errClr)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every byte the consumer accepts must match the next queued byte.
    // It also records the peak FIFO occupancy when requested.
    always @(negedge clk) begin
        if (!rst && rxValid && rxReady) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL pop_unexpected: got %02h, required no byte", rxData);
            end else begin
                logic [7:0] exp;
                exp = expQ.pop_front();
                if (rxData !== exp) begin
                    errors++;
                    $display("[TB] FAIL pop_data: got %02h, required %02h", rxData, exp);
                end
            end
        end
        if (trackMax && int'(fifoCount) > maxCount) maxCount = int'(fifoCount);
    end

    // Advances n cycles, returning 1 time unit after the last rising edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Sends one frame. The byte is queued first when it is expected to be kept.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic badParity, input logic expectKept);
        if (expectKept) expQ.push_back(data);
        uartRx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uartRx = data[i];
            waitCycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uartRx = (^data) ^ badParity;
        waitCycles(CPB);
`endif
        uartRx = stopBit;
        waitCycles(CPB);
        uartRx = 1'b1;
    endtask

    // Directed sequence.
    initial begin
        rst     = 1'b1;
        uartRx  = 1'b1;
        rxReady = 1'b0;
        errClr  = 1'b0;
        waitCycles(5);
        checkOutput("reset_valid", {31'd0, rxValid}, 32'd0);
        checkOutput("reset_data", {24'd0, rxData}, 32'd0);
        rst = 1'b0;
        waitCycles(200);
        checkOutput("idle_valid", {31'd0, rxValid}, 32'd0);
        checkOutput("idle_count", {28'd0, fifoCount}, 32'd0);
        checkOutput("idle_frame_err", {31'd0, frameErr}, 32'd0);
        checkOutput("idle_overrun_err", {31'd0, overrunErr}, 32'd0);

        // Single byte held in the FIFO, then a one-cycle accept.
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
        waitCycles(2);
        checkOutput("single_valid", {31'd0, rxValid}, 32'd1);
        checkOutput("single_data", {24'd0, rxData}, 32'hA5);
        checkOutput("single_count", {28'd0, fifoCount}, 32'd1);
        rxReady = 1'b1;
        waitCycles(1);
        rxReady = 1'b0;
        checkOutput("single_after_pop_valid", {31'd0, rxValid}, 32'd0);
        checkOutput("single_after_pop_count", {28'd0, fifoCount}, 32'd0);

        // A short low pulse must be rejected as a glitch.
        uartRx = 1'b0;
        waitCycles(5);
        uartRx = 1'b1;
        waitCycles(3 * CPB);
        checkOutput("glitch_count", {28'd0, fifoCount}, 32'd0);
        checkOutput("glitch_frame_err", {31'd0, frameErr}, 32'd0);

        // Stop bit low: the byte is discarded and the frame error is flagged.
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        waitCycles(2 * CPB);
        checkOutput("frame_count", {28'd0, fifoCount}, 32'd0);
        checkOutput("frame_err_set", {31'd0, frameErr}, 32'd1);
        errClr = 1'b1;
        waitCycles(1);
        errClr = 1'b0;
        checkOutput("frame_err_clr", {31'd0, frameErr}, 32'd0);

        // Nine bytes into an eight-entry FIFO: the last byte is dropped.
        for (int b = 0; b < 9; b++) begin
            applyStimulus(8'(b), 1'b1, 1'b0, (b < 8) ? 1'b1 : 1'b0);
        end
        waitCycles(CPB);
        checkOutput("overrun_count", {28'd0, fifoCount}, 32'd8);
        checkOutput("overrun_err_set", {31'd0, overrunErr}, 32'd1);
        checkOutput("overrun_head", {24'd0, rxData}, 32'h00);
        rxReady = 1'b1;
        waitCycles(8);
        rxReady = 1'b0;
        checkOutput("drain_count", {28'd0, fifoCount}, 32'd0);
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
        errClr = 1'b1;
        waitCycles(1);
        errClr = 1'b0;
        checkOutput("overrun_err_clr", {31'd0, overrunErr}, 32'd0);

        // Back-to-back frames with the consumer always ready.
        maxCount = 0;
        trackMax = 1'b1;
        rxReady  = 1'b1;
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b1);
        waitCycles(CPB);
        trackMax = 1'b0;
        rxReady  = 1'b0;
        checkOutput("b2b_max_count", 32'(maxCount), 32'd1);
        checkOutput("b2b_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("b2b_count", {28'd0, fifoCount}, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit: the byte is discarded and the parity error is flagged.
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
        waitCycles(CPB);
        checkOutput("parity_err_set", {31'd0, parityErr}, 32'd1);
        checkOutput("parity_count", {28'd0, fifoCount}, 32'd0);
        errClr = 1'b1;
        waitCycles(1);
        errClr = 1'b0;
        checkOutput("parity_err_clr", {31'd0, parityErr}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver front-end driving the CPU-side peripheral from the board pin uart_rx_i.
- Synchronises the serial line, decodes 8N1 frames with mid-bit sampling, and buffers bytes in a small FIFO.
- Presents buffered bytes on a valid/ready byte stream consumed by the AXI UART register block.
- Reports framing and overrun errors as sticky flags.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line baud rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer truncation; 868 at defaults).
- FIFO_DEPTH, 8, receive FIFO entries; power of two, minimum 2.

Ports:
- clk_in  input  1  system clock
- rst  input  1  asynchronous active-high reset
- uart_rx_i  input  1  serial line, idle high, asynchronous to clk_in
- rx_data_o  output  8  byte at FIFO head
- rx_valid_o  output  1  FIFO non-empty
- rx_ready_i  input  1  consumer accepts head byte
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current occupancy
- frame_err_o  output  1  sticky: stop bit sampled low
- overrun_err_o  output  1  sticky: byte dropped because FIFO full
- err_clr_i  input  1  one-cycle pulse clears both sticky flags

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0 (rx_data_o=0x00, rx_valid_o=0, fifo_count_o=0, both error flags 0). Synchroniser flops reset to 1. FSM resets to IDLE.
- Synchroniser: two flops on uart_rx_i; the FSM sees only the second-stage output (rx_s). Line-to-FSM latency is 2 cycles.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: when rx_s=0, load baud counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If rx_s=0, go to DATA with bit index 0. If rx_s=1, treat as a glitch and return to IDLE with nothing written.
  - DATA: every CLKS_PER_BIT cycles sample rx_s into the shift register, LSB first. After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s.
    - If 1: push the byte to the FIFO.
    - If 0: discard the byte, set frame_err_o, and wait in STOP until rx_s=1 before going to IDLE (break condition).
    - On a valid stop, go to IDLE in the same cycle as the sample. A start edge arriving immediately afterwards is accepted.
- FIFO: circular buffer with wrap-around pointers. Write occurs the cycle after the valid stop sample. rx_data_o is driven combinationally from the head entry. Pop occurs when rx_valid_o && rx_ready_i. A push into an empty FIFO shows rx_valid_o=1 on the next cycle (first-word fall-through).
- Full FIFO: a new byte is dropped, overrun_err_o is set, and contents are unchanged.
- Simultaneous push and pop when full: the pop frees the slot, so the push succeeds and there is no overrun.
- Simultaneous push and pop when empty: not possible, since valid=0.
- fifo_count_o is updated the same cycle as the pointers.
- Error flags: err_clr_i clears both flags. If err_clr_i coincides with a new error event, the event wins and the flag stays 1.
- rx_ready_i while rx_valid_o=0 has no effect.
- Reset mid-frame aborts the frame, empties the FIFO, and clears the flags.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples the parity bit after CLKS_PER_BIT cycles. On even-parity mismatch, set sticky output parity_err_o (cleared by err_clr_i) and discard the byte; the stop bit is still checked.
- When undefined: no PARITY state and no parity_err_o port; frames are 8N1.

Test Plan:
- Reset then idle line: hold rst 5 cycles, line high 2000 cycles -> rx_valid_o=0, fifo_count_o=0, both flags 0.
- Single frame 0xA5 at 868 clks/bit, rx_ready_i=0 -> after the stop sample rx_valid_o=1, rx_data_o=0xA5, fifo_count_o=1. Assert rx_ready_i one cycle -> rx_valid_o=0, count 0.
- Glitch: line low 300 cycles then high -> no byte written, FSM back in IDLE, frame_err_o=0.
- Framing error: send 0x3C with stop bit low for 868 cycles, then high -> FIFO empty, frame_err_o=1. Pulse err_clr_i -> frame_err_o=0.
- Overrun: send 9 bytes 0x00..0x08 with rx_ready_i=0 -> count 8, overrun_err_o=1. Drain order must be 0x00..0x07; 0x08 is lost.
- Back-to-back frames with rx_ready_i held 1 and no idle gap, bytes 0x55 then 0xFF -> both received in order, count never exceeds 1. Under UART_RX_PARITY_EN, 0x01 sent with parity bit 0 -> parity_err_o=1, byte discarded.
